// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types, constants and LFSR helper for the LED pattern engine
package led_pattern_pkg;

   typedef enum logic [2:0] {
      ROT_L = 3'd0,
      ROT_R = 3'd1,
      KITT  = 3'd2,
      BAR   = 3'd3,
      RAND  = 3'd4,
      BLINK = 3'd5,
      OFF6  = 3'd6,
      OFF7  = 3'd7
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam logic [15:0] LFSR_TAPS   = 16'hB400;
   localparam logic [3:0]  TRAIL1_DUTY = 4'd4;
   localparam logic [3:0]  TRAIL2_DUTY = 4'd1;

   // Galois right-shift form of x^16+x^14+x^13+x^11; a nonzero state never maps to zero
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - control and LED drive bundle of the LED pattern engine
interface led_pattern_engine_if #(
   parameter int WIDTH   = 8,
   parameter int SPEED_W = 3
);
   import led_pattern_pkg::*;

   mode_e              mode;
   logic [SPEED_W-1:0] speed;
   logic               pause;
   logic               step;
   logic [WIDTH-1:0]   led;
   logic               tick;
   logic               dir;

   modport master (output mode, speed, pause, step, input led, tick, dir);
   modport slave  (input mode, speed, pause, step, output led, tick, dir);

endinterface

// File: rtl/pattern_tick_gen.sv
// rtl/pattern_tick_gen.sv - programmable-rate step tick divider with pause and clear
module pattern_tick_gen #(
   parameter int DIV_W   = 22,
   parameter int SPEED_W = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [SPEED_W-1:0] speed,
   input  logic               pause,
   input  logic               clear,
   output logic               tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] term;

   // >= rather than == so a speed-up past the current count wraps on the next edge
   assign term = {DIV_W{1'b1}} >> speed;
   assign tick = !pause && (cnt >= term);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (pause || clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED animation engine; LED_PATTERN_TRAIL_EN adds a PWM fading trail in KITT mode
module led_pattern_engine
   import led_pattern_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int          DIV_W     = 22,
   parameter int          SPEED_W   = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic                 clock,
   input logic                 reset,
   led_pattern_engine_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   mode_e            mode_q;
   dir_e             dir_q, dir_d;
   logic [WIDTH-1:0] pat, pat_d;
   logic [15:0]      lfsr, lfsr_d, lfsr_nxt;
   logic             tick_q;
   logic             tick, step, reload, apply;

   pattern_tick_gen #(.DIV_W(DIV_W), .SPEED_W(SPEED_W)) u_tick (
      .clock (clock),
      .reset (reset),
      .speed (bus.speed),
      .pause (bus.pause),
      .clear (reload),
      .tick  (tick)
   );

   assign reload   = (bus.mode != mode_q);
   assign step     = tick | (bus.step & bus.pause);
   assign apply    = step & !reload;
   assign lfsr_nxt = lfsr_next(lfsr);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pat    <= ONE;
         dir_q  <= DIR_UP;
         lfsr   <= LFSR_SEED;
         mode_q <= ROT_L;
         tick_q <= 1'b0;
      end else begin
         pat    <= pat_d;
         dir_q  <= dir_d;
         lfsr   <= lfsr_d;
         mode_q <= bus.mode;
         tick_q <= apply;
      end
   end

   always_comb begin
      pat_d  = pat;
      dir_d  = dir_q;
      lfsr_d = lfsr;
      if (reload) begin
         dir_d = DIR_UP;
         case (bus.mode)
            ROT_L, ROT_R, KITT: pat_d = ONE;
            RAND:               pat_d = WIDTH'(lfsr);
            BLINK:              pat_d = ONES;
            default:            pat_d = '0;
         endcase
      end else if (apply) begin
         case (mode_q)
            ROT_L: pat_d = {pat[WIDTH-2:0], pat[WIDTH-1]};
            ROT_R: pat_d = {pat[0], pat[WIDTH-1:1]};
            KITT: begin
               if (dir_q == DIR_UP) begin
                  if (pat[WIDTH-1]) begin
                     pat_d = ONE << (WIDTH - 2);
                     dir_d = DIR_DOWN;
                  end else begin
                     pat_d = pat << 1;
                  end
               end else if (pat[0]) begin
                  pat_d = ONE << 1;
                  dir_d = DIR_UP;
               end else begin
                  pat_d = pat >> 1;
               end
            end
            BAR: begin
               if (dir_q == DIR_UP) begin
                  if (pat == ONES) begin
                     pat_d = pat >> 1;
                     dir_d = DIR_DOWN;
                  end else begin
                     pat_d = {pat[WIDTH-2:0], 1'b1};
                  end
               end else if (pat == '0) begin
                  pat_d = ONE;
                  dir_d = DIR_UP;
               end else begin
                  pat_d = pat >> 1;
               end
            end
            RAND: begin
               lfsr_d = lfsr_nxt;
               pat_d  = WIDTH'(lfsr_nxt);
            end
            BLINK:   pat_d = (pat == ONES) ? '0 : ONES;
            default: pat_d = '0;
         endcase
      end
   end

   assign bus.tick = tick_q;
   assign bus.dir  = dir_q;

`ifdef LED_PATTERN_TRAIL_EN
   logic [3:0]       pwm;
   logic [WIDTH-1:0] hist1, hist2;

   // history survives a direction reversal; only reset and a mode change clear it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pwm   <= '0;
         hist1 <= '0;
         hist2 <= '0;
      end else begin
         pwm <= pwm + 1'b1;
         if (reload) begin
            hist1 <= '0;
            hist2 <= '0;
         end else if (apply && mode_q == KITT) begin
            hist1 <= pat;
            hist2 <= hist1;
         end
      end
   end

   assign bus.led = (mode_q == KITT)
                  ? (pat | ((pwm < TRAIL1_DUTY) ? hist1 : '0) | ((pwm < TRAIL2_DUTY) ? hist2 : '0))
                  : pat;
`else
   assign bus.led = pat;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed self-checking bench for led_pattern_engine
module tb_led_pattern_engine;
   import led_pattern_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int passed = 0;
   int total  = 0;

   led_pattern_engine_if #(.WIDTH(8), .SPEED_W(2)) bus ();

   led_pattern_engine #(
      .WIDTH(8), .DIV_W(4), .SPEED_W(2), .LFSR_SEED(16'hACE1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      mode_e      mode;
      logic [1:0] speed;
      logic [7:0] led;
      logic       dir;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input mode_e m, input logic [1:0] s, input logic [7:0] l, input logic d);
      vec_t v;
      v.mode = m; v.speed = s; v.led = l; v.dir = d;
      vt.push_back(v);
   endtask

   task automatic wait_tick(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         n++;
         if (bus.tick) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit         ok;
      int         n, err, run, stuck, cnt;
      mode_e      prev;
      logic [15:0] model;
      logic [7:0]  last;

      // expected step sequences, hand-derived from the mode definitions
      add(ROT_L,0,8'h08,0); add(ROT_L,0,8'h10,0); add(ROT_L,0,8'h20,0);
      add(ROT_L,0,8'h40,0); add(ROT_L,0,8'h80,0); add(ROT_L,0,8'h01,0);
      add(KITT,2,8'h01,0);
      add(KITT,2,8'h02,0); add(KITT,2,8'h04,0); add(KITT,2,8'h08,0); add(KITT,2,8'h10,0);
      add(KITT,2,8'h20,0); add(KITT,2,8'h40,0); add(KITT,2,8'h80,0);
      add(KITT,2,8'h40,1); add(KITT,2,8'h20,1); add(KITT,2,8'h10,1); add(KITT,2,8'h08,1);
      add(KITT,2,8'h04,1); add(KITT,2,8'h02,1); add(KITT,2,8'h01,1); add(KITT,2,8'h02,0);
      add(BAR,2,8'h00,0);
      add(BAR,2,8'h01,0); add(BAR,2,8'h03,0); add(BAR,2,8'h07,0); add(BAR,2,8'h0F,0);
      add(BAR,2,8'h1F,0); add(BAR,2,8'h3F,0); add(BAR,2,8'h7F,0); add(BAR,2,8'hFF,0);
      add(BAR,2,8'h7F,1); add(BAR,2,8'h3F,1); add(BAR,2,8'h1F,1); add(BAR,2,8'h0F,1);
      add(BAR,2,8'h07,1); add(BAR,2,8'h03,1); add(BAR,2,8'h01,1); add(BAR,2,8'h00,1);
      add(BAR,2,8'h01,0);
      add(ROT_R,2,8'h01,0); add(ROT_R,2,8'h80,0); add(ROT_R,2,8'h40,0);
      add(BLINK,3,8'hFF,0); add(BLINK,3,8'h00,0); add(BLINK,3,8'hFF,0);
      add(OFF6,3,8'h00,0);  add(OFF6,3,8'h00,0);
      add(RAND,3,8'hE1,0);
      add(RAND,3,8'h70,0); add(RAND,3,8'h38,0); add(RAND,3,8'h9C,0);
      add(RAND,3,8'h4E,0); add(RAND,3,8'h27,0); add(RAND,3,8'h13,0);

      bus.mode = ROT_L; bus.speed = 2'd0; bus.pause = 1'b0; bus.step = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("reset_led", bus.led, 8'h01);
      check("reset_tick", bus.tick, 1'b0);
      check("reset_dir", bus.dir, 1'b0);

      wait_tick(40, ok, n);
      check("rotl_first_tick", ok, 1'b1);
      check("rotl_led_1", bus.led, 8'h02);
      wait_tick(40, ok, n);
      check("rotl_period", n, 16);
      check("rotl_led_2", bus.led, 8'h04);

      prev = ROT_L;
      foreach (vt[i]) begin
         bus.mode  = vt[i].mode;
         bus.speed = vt[i].speed;
         if (vt[i].mode != prev) begin
            @(negedge clock);
            check($sformatf("vec%0d_reload_tick", i), bus.tick, 1'b0);
         end else begin
            wait_tick(40, ok, n);
            check($sformatf("vec%0d_tick_seen", i), ok, 1'b1);
         end
         check($sformatf("vec%0d_led", i), bus.led, vt[i].led);
         check($sformatf("vec%0d_dir", i), bus.dir, vt[i].dir);
         prev = vt[i].mode;
      end

      // long random run driven one step per clock through paused single-step
      model = 16'hB313;
      err = 0; run = 0; stuck = 0; last = bus.led;
      bus.pause = 1'b1; bus.step = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clock);
         model = model[0] ? ((model >> 1) ^ 16'hB400) : (model >> 1);
         if (bus.led !== model[7:0]) err++;
         if (bus.led == last) run++; else run = 0;
         if (run > 16) stuck = 1;
         last = bus.led;
      end
      bus.step = 1'b0;
      check("rand_track_errors", err, 0);
      check("rand_stuck", stuck, 0);

      // pause freezes, a single step pulse advances exactly once
      bus.pause = 1'b0; bus.mode = ROT_L; bus.speed = 2'd2;
      @(negedge clock);
      check("rand_to_rotl_led", bus.led, 8'h01);
      bus.pause = 1'b1;
      err = 0;
      repeat (100) begin
         @(negedge clock);
         if (bus.tick !== 1'b0 || bus.led !== 8'h01) err++;
      end
      check("pause_frozen", err, 0);
      bus.step = 1'b1;
      @(negedge clock);
      bus.step = 1'b0;
      cnt = bus.tick;
      repeat (9) begin
         @(negedge clock);
         cnt += bus.tick;
      end
      check("step_tick_count", cnt, 1);
      check("step_led", bus.led, 8'h02);
      bus.pause = 1'b0;

      // mode change landing on a tick cycle: reload only, no step
      wait_tick(40, ok, n);
      check("pre_switch_tick", ok, 1'b1);
      repeat (3) @(negedge clock);
      bus.mode = BLINK;
      @(negedge clock);
      check("switch_led", bus.led, 8'hFF);
      check("switch_no_tick", bus.tick, 1'b0);
      wait_tick(40, ok, n);
      check("blink_first_delay", n, 4);
      check("blink_led_0", bus.led, 8'h00);
      wait_tick(40, ok, n);
      check("blink_led_1", bus.led, 8'hFF);

      // speed-up while the count is past the new terminal
      bus.speed = 2'd0;
      cnt = 0;
      repeat (8) begin
         @(negedge clock);
         cnt += bus.tick;
      end
      check("slow_no_tick", cnt, 0);
      bus.speed = 2'd2;
      @(negedge clock);
      check("speedup_tick", bus.tick, 1'b1);

      // asynchronous reset in the middle of a KITT return sweep
      bus.mode = KITT;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         if (bus.dir) begin
            ok = 1'b1;
            break;
         end
      end
      check("kitt_reached_down", ok, 1'b1);
      #3 reset = 1'b1;
      #1;
      check("midrun_reset_led", bus.led, 8'h01);
      check("midrun_reset_dir", bus.dir, 1'b0);
      check("midrun_reset_tick", bus.tick, 1'b0);
      bus.mode = ROT_L;
      @(negedge clock);
      reset = 1'b0;
      wait_tick(40, ok, n);
      check("post_reset_led", bus.led, 8'h02);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
